// File: rtl/judge_run_ctrl_if.sv
// Harness-side bundle for judge_run_ctrl: stimulus/reference in, verdict out.
interface judge_run_ctrl_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [WIDTH-1:0] dut_y;
  logic [WIDTH-1:0] ref_y;
  logic             mismatch;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             first_err_valid;
  logic [CNT_W-1:0] first_err_cycle;

  modport master (
    output start, dut_y, ref_y,
    input  mismatch, busy, done, pass, mismatch_cnt, first_err_valid, first_err_cycle
  );

  modport slave (
    input  start, dut_y, ref_y,
    output mismatch, busy, done, pass, mismatch_cnt, first_err_valid, first_err_cycle
  );
endinterface

// File: rtl/judge_run_ctrl.sv
// judge_run_ctrl: judges one run of dut_y against ref_y over a fixed window.
// Optional build macro JUDGE_STOP_ON_FIRST_ERR_EN: abort the run on the first
// mismatch (mismatch_cnt = 1, pass = 0); undefined, the whole window is judged.
module judge_run_ctrl #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned RUN_CYCLES    = 40,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  judge_run_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [7:0]       settle_cnt_q;
  logic [CNT_W-1:0] cyc_idx_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic [CNT_W-1:0] mis_cnt_d;
  logic [CNT_W-1:0] first_cycle_q;
  logic             first_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [WIDTH-1:0] dut_w;
  logic [WIDTH-1:0] ref_w;
  logic             hit;
  logic             last_cyc;

  assign dut_w = bus.dut_y;
  assign ref_w = bus.ref_y;

  // Compare only inside the judged window; an X compare result falls through the if and is not a hit.
  always_comb begin
    hit = 1'b0;
    if ((state_q == S_RUN) && (dut_w != ref_w)) begin
      hit = 1'b1;
    end
  end

  // Saturating next value of the mismatch counter.
  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (mis_cnt_q != '1) begin
      mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  assign last_cyc = (cyc_idx_q == CNT_W'(RUN_CYCLES - 1));

  // Run sequencer with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      settle_cnt_q  <= '0;
      cyc_idx_q     <= '0;
      mis_cnt_q     <= '0;
      first_cycle_q <= '0;
      first_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            settle_cnt_q  <= '0;
            cyc_idx_q     <= '0;
            mis_cnt_q     <= '0;
            first_cycle_q <= '0;
            first_valid_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            state_q       <= (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
            state_q <= S_RUN;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end

        S_RUN: begin
          cyc_idx_q <= cyc_idx_q + 1'b1;
          if (hit && !first_valid_q) begin
            first_valid_q <= 1'b1;
            first_cycle_q <= cyc_idx_q;
          end
`ifdef JUDGE_STOP_ON_FIRST_ERR_EN
          if (hit) begin
            mis_cnt_q <= CNT_W'(1);
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
          end else if (last_cyc) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (mis_cnt_q == '0);
          end
`else
          if (hit) begin
            mis_cnt_q <= mis_cnt_d;
          end
          // The final compare lands on the same edge as the verdict, so fold it into pass.
          if (last_cyc) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (mis_cnt_q == '0) && !hit;
          end
`endif
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mismatch        = hit;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.mismatch_cnt    = mis_cnt_q;
  assign bus.first_err_valid = first_valid_q;
  assign bus.first_err_cycle = first_cycle_q;

endmodule

// File: tb/tb_judge_run_ctrl.sv
// Bench for judge_run_ctrl: a default instance and a CNT_W=3/RUN_CYCLES=7 instance
// share clock, reset and dut_y/ref_y; results are predicted from the window rules.
module tb_judge_run_ctrl;

  localparam int S   = 1;
  localparam int RA  = 40;
  localparam int CWA = 16;
  localparam int RB  = 7;
  localparam int CWB = 3;
  localparam int LEN = 45;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  judge_run_ctrl_if #(.WIDTH(1), .CNT_W(CWA)) a_if ();
  judge_run_ctrl_if #(.WIDTH(1), .CNT_W(CWB)) b_if ();

  judge_run_ctrl #(
    .WIDTH(1), .SETTLE_CYCLES(S), .RUN_CYCLES(RA), .CNT_W(CWA)
  ) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  judge_run_ctrl #(
    .WIDTH(1), .SETTLE_CYCLES(S), .RUN_CYCLES(RB), .CNT_W(CWB)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic dv [64];
  logic rv [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected verdict from the vectors: edge j samples dv[j]/rv[j], start is sampled
  // at edge 0, window index k is sampled at edge S+1+k, done appears after edge de.
  task automatic model(input int r, input int cw, output int cnt, output bit fv,
                       output int fc, output int de);
    cnt = 0; fv = 0; fc = 0; de = S + r;
    for (int k = 0; k < r; k++) begin
      if (dv[S+1+k] != rv[S+1+k]) begin
        if (!fv) begin
          fv = 1;
          fc = k;
        end
        if (cnt < (1 << cw) - 1) cnt++;
      end
    end
`ifdef JUDGE_STOP_ON_FIRST_ERR_EN
    if (fv) begin
      cnt = 1;
      de  = S + 1 + fc;
    end
`endif
  endtask

  task automatic drive(input int j, input logic sa, input logic sb);
    a_if.start = sa;
    b_if.start = sb;
    a_if.dut_y = dv[j];
    a_if.ref_y = rv[j];
    b_if.dut_y = dv[j];
    b_if.ref_y = rv[j];
  endtask

  task automatic check_zero(input string who);
    chk({who, "_a_busy"}, 32'(a_if.busy), 32'd0);
    chk({who, "_a_done"}, 32'(a_if.done), 32'd0);
    chk({who, "_a_pass"}, 32'(a_if.pass), 32'd0);
    chk({who, "_a_cnt"},  32'(a_if.mismatch_cnt), 32'd0);
    chk({who, "_a_fv"},   32'(a_if.first_err_valid), 32'd0);
    chk({who, "_a_fc"},   32'(a_if.first_err_cycle), 32'd0);
    chk({who, "_a_mis"},  32'(a_if.mismatch), 32'd0);
    chk({who, "_b_busy"}, 32'(b_if.busy), 32'd0);
    chk({who, "_b_done"}, 32'(b_if.done), 32'd0);
    chk({who, "_b_cnt"},  32'(b_if.mismatch_cnt), 32'd0);
    chk({who, "_b_fv"},   32'(b_if.first_err_valid), 32'd0);
  endtask

  // One full run on both instances, checked cycle by cycle and at the end.
  task automatic run_check(input string tag);
    int ca, cb, fca, fcb, dea, deb;
    bit fva, fvb;
    model(RA, CWA, ca, fva, fca, dea);
    model(RB, CWB, cb, fvb, fcb, deb);
    for (int j = 0; j < LEN; j++) begin
      @(negedge clk);
      drive(j, logic'(j == 0), logic'(j == 0));
      #1;
      chk({tag, "_a_mis"}, 32'(a_if.mismatch),
          32'((j >= S + 1) && (j <= dea) && (dv[j] != rv[j])));
      chk({tag, "_b_mis"}, 32'(b_if.mismatch),
          32'((j >= S + 1) && (j <= deb) && (dv[j] != rv[j])));
      if (j >= 1) begin
        chk({tag, "_a_busy"}, 32'(a_if.busy), 32'((j - 1) < dea));
        chk({tag, "_a_done"}, 32'(a_if.done), 32'((j - 1) >= dea));
        chk({tag, "_b_busy"}, 32'(b_if.busy), 32'((j - 1) < deb));
        chk({tag, "_b_done"}, 32'(b_if.done), 32'((j - 1) >= deb));
      end
    end
    @(negedge clk);
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    #1;
    chk({tag, "_a_cnt"},  32'(a_if.mismatch_cnt), 32'(ca));
    chk({tag, "_a_fv"},   32'(a_if.first_err_valid), 32'(fva));
    chk({tag, "_a_fc"},   32'(a_if.first_err_cycle), 32'(fca));
    chk({tag, "_a_pass"}, 32'(a_if.pass), 32'(ca == 0));
    chk({tag, "_a_done"}, 32'(a_if.done), 32'd1);
    chk({tag, "_b_cnt"},  32'(b_if.mismatch_cnt), 32'(cb));
    chk({tag, "_b_fv"},   32'(b_if.first_err_valid), 32'(fvb));
    chk({tag, "_b_fc"},   32'(b_if.first_err_cycle), 32'(fcb));
    chk({tag, "_b_pass"}, 32'(b_if.pass), 32'(cb == 0));
    chk({tag, "_b_done"}, 32'(b_if.done), 32'd1);
  endtask

  task automatic fill_const(input logic d, input logic r);
    for (int j = 0; j < 64; j++) begin
      dv[j] = d;
      rv[j] = r;
    end
  endtask

  task automatic fill_rand(input int dens);
    for (int j = 0; j < 64; j++) begin
      rv[j] = logic'($urandom_range(0, 1));
      dv[j] = ($urandom_range(0, 9) < dens) ? ~rv[j] : rv[j];
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    fill_const(1'b0, 1'b0);
    drive(0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_zero("idle");

    // Clean run, then everything wrong, then two isolated errors.
    fill_const(1'b0, 1'b0);
    run_check("clean");
    fill_const(1'b1, 1'b0);
    run_check("allbad");
    fill_const(1'b0, 1'b0);
    dv[S+1+7]  = 1'b1;
    dv[S+1+20] = 1'b1;
    run_check("pulse");

    // Differences only outside the judged window.
    fill_const(1'b0, 1'b0);
    for (int j = 0; j <= S; j++) dv[j] = 1'b1;
    for (int j = S + RA + 1; j < 64; j++) dv[j] = 1'b1;
    run_check("outside");

    // Random runs at assorted error densities.
    for (int it = 0; it < 8; it++) begin
      fill_rand(it % 5);
      run_check($sformatf("rand%0d", it));
    end

    // Start re-pulsed mid-run is ignored; reset mid-run discards the run.
    fill_const(1'b0, 1'b0);
`ifndef JUDGE_STOP_ON_FIRST_ERR_EN
    dv[S+1+9] = 1'b1;
`endif
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      drive(j, logic'((j == 0) || (j == S + 1 + 10)), 1'b0);
    end
    @(negedge clk);
    drive(17, 1'b0, 1'b0);
    #1;
    chk("repulse_busy", 32'(a_if.busy), 32'd1);
`ifndef JUDGE_STOP_ON_FIRST_ERR_EN
    chk("repulse_cnt", 32'(a_if.mismatch_cnt), 32'd1);
    chk("repulse_fc",  32'(a_if.first_err_cycle), 32'd9);
`endif
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand(2);
    run_check("fresh");

    // Back-to-back restart from DONE.
    fill_const(1'b1, 1'b0);
    run_check("again");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
